// File: rtl/door_controller_ext_if.sv
// Sensor/motor bundle between the door sensors, the controller and the motor driver.
// master = sensor/test side, slave = controller.
interface door_controller_ext_if;
  logic       Activate;
  logic       UP_Max;
  logic       DN_Max;
  logic       Obstruct;
  logic       UP_Motor;
  logic       DN_Motor;
  logic       Fault;
  logic [2:0] State_Out;

  modport master (
    output Activate, UP_Max, DN_Max, Obstruct,
    input  UP_Motor, DN_Motor, Fault, State_Out
  );

  modport slave (
    input  Activate, UP_Max, DN_Max, Obstruct,
    output UP_Motor, DN_Motor, Fault, State_Out
  );
endinterface

// File: rtl/door_controller_ext.sv
// Garage-door Moore controller: edge-detected push-button, stop/reverse, obstruction
// safety-reverse, motion watchdog with latched fault, optional auto-close.
module door_controller_ext #(
  parameter int MOVE_TIMEOUT = 1000,
  parameter int AUTO_CLOSE   = 500,
  parameter int CNT_W        = 16
) (
  input logic                 CLK,
  input logic                 RST,
  door_controller_ext_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MV_UP     = 3'd1,
    MV_DN     = 3'd2,
    STOPPED   = 3'd3,
    OPEN_HOLD = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam bit             AC_EN    = (AUTO_CLOSE > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AC_LAST  = CNT_W'(AC_EN ? AUTO_CLOSE - 1 : 0);
  // With auto-close disabled a fully opened door simply parks in IDLE.
  localparam state_t         UP_DONE  = state_t'(AC_EN ? OPEN_HOLD : IDLE);

  state_t           state, nxt;
  logic [CNT_W-1:0] timer;
  logic             act_prev;
  logic             last_dir;

  logic act, up_lim, dn_lim, obs;
  logic act_pulse, both_lim, tmo_hit, ac_hit;

  assign act       = bus.Activate;
  assign up_lim    = bus.UP_Max;
  assign dn_lim    = bus.DN_Max;
  assign obs       = bus.Obstruct;
  assign act_pulse = act & ~act_prev;
  assign both_lim  = up_lim & dn_lim;
  assign tmo_hit   = (timer == TMO_LAST);
  assign ac_hit    = AC_EN && (timer == AC_LAST);

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: begin
        if (!act_pulse)    nxt = IDLE;
        else if (both_lim) nxt = FAULT;
        else if (up_lim)   nxt = MV_DN;
        else               nxt = MV_UP;
      end
      MV_UP: begin
        if (both_lim)       nxt = FAULT;
        else if (up_lim)    nxt = UP_DONE;
        else if (tmo_hit)   nxt = FAULT;
        else if (act_pulse) nxt = STOPPED;
        else                nxt = MV_UP;
      end
      MV_DN: begin
        if (both_lim)       nxt = FAULT;
        else if (dn_lim)    nxt = IDLE;
        else if (obs)       nxt = MV_UP;
        else if (tmo_hit)   nxt = FAULT;
        else if (act_pulse) nxt = STOPPED;
        else                nxt = MV_DN;
      end
      STOPPED: begin
        nxt = STOPPED;
        // Reopening is always allowed; closing waits for a clear beam.
        if (act_pulse) begin
          if (last_dir)  nxt = MV_UP;
          else if (!obs) nxt = MV_DN;
        end
      end
      OPEN_HOLD: begin
        nxt = OPEN_HOLD;
        if (!obs && (act_pulse || ac_hit)) nxt = MV_DN;
      end
      FAULT:   nxt = FAULT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      timer         <= '0;
      act_prev      <= 1'b0;
      last_dir      <= 1'b0;
      bus.UP_Motor  <= 1'b0;
      bus.DN_Motor  <= 1'b0;
      bus.Fault     <= 1'b0;
      bus.State_Out <= 3'd0;
    end else begin
      state    <= nxt;
      act_prev <= act;

      // A broken beam keeps the auto-close countdown parked at zero.
      if (nxt != state)                   timer <= '0;
      else if (state == OPEN_HOLD && obs) timer <= '0;
      else if (timer != '1)               timer <= timer + 1'b1;

      if (nxt == MV_UP)      last_dir <= 1'b0;
      else if (nxt == MV_DN) last_dir <= 1'b1;

      bus.UP_Motor  <= (nxt == MV_UP);
      bus.DN_Motor  <= (nxt == MV_DN);
      bus.Fault     <= (nxt == FAULT);
      bus.State_Out <= nxt;
    end
  end

endmodule

// File: tb/tb_door_controller_ext.sv
// Directed walk through the door scenarios, then random sensor traffic, all
// checked cycle by cycle against a rule-level model of the door.
module tb_door_controller_ext;

  localparam int TMO = 20;
  localparam int AC  = 10;

  localparam int S_IDLE = 0, S_UP = 1, S_DN = 2, S_STOP = 3, S_HOLD = 4, S_FLT = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  door_controller_ext_if bus ();

  door_controller_ext #(.MOVE_TIMEOUT(TMO), .AUTO_CLOSE(AC), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: where the door controller is, how long it has been there
  int m_st    = S_IDLE;
  int m_dwell = 0;
  bit m_prev  = 1'b0;
  bit m_down  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, act, upm, dnm, obs);
    bit press, jam;
    int nx;
    if (rst) begin
      m_st = S_IDLE; m_dwell = 0; m_prev = 0; m_down = 0;
      return;
    end
    press = act && !m_prev;
    jam   = upm && dnm;
    nx    = m_st;
    if (m_st == S_IDLE && press)
      nx = jam ? S_FLT : (upm ? S_DN : S_UP);
    else if (m_st == S_UP) begin
      if (jam)                      nx = S_FLT;
      else if (upm)                 nx = S_HOLD;
      else if (m_dwell + 1 >= TMO)  nx = S_FLT;
      else if (press)               nx = S_STOP;
    end else if (m_st == S_DN) begin
      if (jam)                      nx = S_FLT;
      else if (dnm)                 nx = S_IDLE;
      else if (obs)                 nx = S_UP;
      else if (m_dwell + 1 >= TMO)  nx = S_FLT;
      else if (press)               nx = S_STOP;
    end else if (m_st == S_STOP && press) begin
      if (m_down)    nx = S_UP;
      else if (!obs) nx = S_DN;
    end else if (m_st == S_HOLD && !obs && (press || m_dwell + 1 >= AC))
      nx = S_DN;

    if (nx != m_st || (m_st == S_HOLD && obs)) m_dwell = 0;
    else if (m_dwell < 65535)                  m_dwell++;
    if (nx == S_UP) m_down = 0;
    if (nx == S_DN) m_down = 1;
    m_st   = nx;
    m_prev = act;
  endtask

  task automatic tick(input bit rst, act, upm, dnm, obs);
    @(negedge CLK);
    RST          = rst;
    bus.Activate = act;
    bus.UP_Max   = upm;
    bus.DN_Max   = dnm;
    bus.Obstruct = obs;
    @(posedge CLK);
    model_step(rst, act, upm, dnm, obs);
    #1;
    chk("state", int'(bus.State_Out), m_st);
    chk("up_motor", int'(bus.UP_Motor), int'(m_st == S_UP));
    chk("dn_motor", int'(bus.DN_Motor), int'(m_st == S_DN));
    chk("fault", int'(bus.Fault), int'(m_st == S_FLT));
    chk("motor_mutex", int'(bus.UP_Motor & bus.DN_Motor), 0);
  endtask

  initial begin
    bit a;
    int flt_age;

    // reset state
    tick(1, 0, 0, 1, 0);
    chk("rst_state", int'(bus.State_Out), 0);

    // full cycle from closed: open, auto-close, land closed
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 0);
    chk("tp1_mv_up", int'(bus.UP_Motor), 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("tp1_hold", int'(bus.State_Out), S_HOLD);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 0);
    chk("tp1_hold_9", int'(bus.State_Out), S_HOLD);
    tick(0, 0, 1, 0, 0);
    chk("tp1_autoclose", int'(bus.DN_Motor), 1);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk("tp1_closed", int'(bus.State_Out), S_IDLE);

    // obstruction on cycle 3 of closing
    tick(1, 0, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    chk("tp2_mv_dn", int'(bus.State_Out), S_DN);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("tp2_reverse", int'(bus.State_Out), S_UP);

    // watchdog from unknown position
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick(0, 0, 0, 0, 0);
    chk("tp3_pre_tmo", int'(bus.State_Out), S_UP);
    tick(0, 0, 0, 0, 0);
    chk("tp3_fault", int'(bus.Fault), 1);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0);
    chk("tp3_absorb", int'(bus.State_Out), S_FLT);
    tick(1, 0, 0, 0, 0);
    chk("tp3_clear", int'(bus.Fault), 0);

    // held button, stop, reverse
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick(0, 1, 0, (i == 0), 0);
    chk("tp4_held", int'(bus.State_Out), S_UP);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("tp4_stop", int'(bus.State_Out), S_STOP);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("tp4_reverse", int'(bus.State_Out), S_DN);

    // obstruction parks auto-close
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, 0, 1, 0, 1);
    chk("tp5_parked", int'(bus.State_Out), S_HOLD);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("tp5_close", int'(bus.State_Out), S_DN);

    // both limits while closing, reset while opening
    tick(0, 0, 1, 1, 0);
    chk("tp6_both", int'(bus.State_Out), S_FLT);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("tp6_rst_motor", int'(bus.UP_Motor), 0);

    // random traffic; calm phases let the watchdog fire
    a = 0;
    flt_age = 0;
    for (int n = 0; n < 3000; n++) begin
      bit calm, r, u, d, o;
      calm = ((n / 400) % 2) == 1;
      if ($urandom_range(0, 3) == 0) a = ~a;
      u = calm ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0);
      d = calm ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0);
      o = ($urandom_range(0, 6) == 0);
      flt_age = (m_st == S_FLT) ? flt_age + 1 : 0;
      r = ($urandom_range(0, 149) == 0) || (flt_age > 5);
      tick(r, a, u, d, o);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/door_controller_ext.md
Name: door_controller_ext

Overview:
- Parametrised successor to the basic garage-door Moore FSM. It drives an up/down motor pair from a push-button and two end-of-travel limit switches.
- Adds the following beyond the basic FSM:
  - rising-edge Activate detection
  - stop/reverse mid-travel
  - obstruction safety-reverse while closing
  - motion watchdog timeout with latched fault
  - optional auto-close after the door reaches full open
- Sits between debounced/synchronised door sensors and the motor driver stage.

Parameters:
- MOVE_TIMEOUT, 1000: max cycles allowed in MV_UP or MV_DN before FAULT; must be ≥ 2.
- AUTO_CLOSE, 500: cycles held in OPEN_HOLD before closing automatically; 0 disables auto-close (MV_UP with UP_Max goes to IDLE).
- CNT_W, 16: timer width; must hold max(MOVE_TIMEOUT, AUTO_CLOSE).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- Activate  in  1  push-button level, already synchronised/debounced
- UP_Max  in  1  high when door is fully open
- DN_Max  in  1  high when door is fully closed
- Obstruct  in  1  safety beam broken, level
- UP_Motor  out  1  drive motor up
- DN_Motor  out  1  drive motor down
- Fault  out  1  latched fault indicator
- State_Out  out  3  current state code

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE, timer=0, act_prev=0, last_dir=0 (up).
  - All outputs are 0 from the following cycle.
  - Reset mid-motion stops the motors on the next edge.
- Activate handling:
  - act_pulse = Activate & ~act_prev, where act_prev is Activate registered.
  - Holding Activate high produces exactly one pulse.
- Timer:
  - Counts cycles spent in the current state; value 0 in the entry cycle.
  - Clears on every state change; saturates at all-ones.
- State codes: IDLE=0, MV_UP=1, MV_DN=2, STOPPED=3, OPEN_HOLD=4, FAULT=5. Unused codes go to IDLE next cycle.
- Outputs are Moore-decoded from the state register:
  - UP_Motor=1 only in MV_UP.
  - DN_Motor=1 only in MV_DN.
  - Fault=1 only in FAULT.
  - UP_Motor and DN_Motor are never both 1.
- Transitions (listed in priority order per state; the first matching condition wins):
  - IDLE:
    - no act_pulse → stay
    - UP_Max & DN_Max → FAULT
    - UP_Max → MV_DN
    - DN_Max → MV_UP
    - neither limit (position unknown) → MV_UP
  - MV_UP (last_dir=0):
    - UP_Max & DN_Max → FAULT
    - UP_Max → OPEN_HOLD (IDLE if AUTO_CLOSE=0)
    - timer == MOVE_TIMEOUT-1 → FAULT
    - act_pulse → STOPPED
    - Obstruct is ignored.
  - MV_DN (last_dir=1):
    - UP_Max & DN_Max → FAULT
    - DN_Max → IDLE
    - Obstruct → MV_UP (safety reverse; timer restarts)
    - timer == MOVE_TIMEOUT-1 → FAULT
    - act_pulse → STOPPED
  - STOPPED:
    - act_pulse → MV_DN if last_dir=0, else MV_UP
    - Obstruct does not block reopening. It does block closing: an act_pulse that would select MV_DN while Obstruct=1 is ignored.
  - OPEN_HOLD:
    - act_pulse → MV_DN, unless Obstruct=1
    - Obstruct=1 holds the timer at 0
    - timer == AUTO_CLOSE-1 with Obstruct=0 → MV_DN
  - FAULT: absorbing; exits only via RST.
- last_dir updates on entry to MV_UP (0) or MV_DN (1).
- Timeout therefore fires with the motor active for exactly MOVE_TIMEOUT cycles.
- Simultaneous events resolve by the priority order above. Examples:
  - DN_Max with Obstruct in MV_DN → IDLE.
  - UP_Max with act_pulse in MV_UP → OPEN_HOLD.

Test Plan (MOVE_TIMEOUT=20, AUTO_CLOSE=10):
- Closed door: DN_Max=1, pulse Activate → MV_UP next cycle, UP_Motor=1. Raise UP_Max after 5 cycles → OPEN_HOLD; 10 cycles later → MV_DN, DN_Motor=1. Raise DN_Max → IDLE, both motors 0.
- Closing with Obstruct asserted at cycle 3 of MV_DN → MV_UP next cycle, UP_Motor=1, DN_Motor=0, State_Out=1.
- Moving up with no limit reached → FAULT exactly 20 cycles after entering MV_UP, Fault=1, motors 0. Further Activate pulses leave FAULT unchanged; RST=1 for one cycle → IDLE, Fault=0.
- Activate held high for 8 cycles from IDLE with DN_Max=1 → single transition to MV_UP, no STOPPED. A second pulse mid-travel → STOPPED, motors 0. A third pulse → MV_DN (reverse).
- OPEN_HOLD with Obstruct=1 for 30 cycles → remains in OPEN_HOLD. Release Obstruct → MV_DN 10 cycles later.
- UP_Max=DN_Max=1 during MV_DN → FAULT next cycle. RST asserted during MV_UP → UP_Motor=0 after that edge, State_Out=0.
